// File: rtl/sbox_nibble_sched.sv
// Feeds the four nibbles of a two-share 16-bit state through one shared masked SBox.
// A valid/tag pipe follows each nibble through the SBox so both shares can be reassembled.
module sbox_nibble_sched #(
  parameter int SBOX_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] state_a,
  input  logic [15:0] state_b,
  input  logic [3:0]  round,
  input  logic [17:0] rnd_in,
  input  logic        rnd_valid,
  output logic        rnd_ack,
  output logic [3:0]  sb_a_in,
  output logic [3:0]  sb_b_in,
  output logic [17:0] sb_rnd,
  output logic [3:0]  sb_round,
  input  logic [3:0]  sb_a_out,
  input  logic [3:0]  sb_b_out,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic        busy,
  output logic        done,
  output logic        rnd_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} st_e;

  st_e         st_q, st_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] oa_q, oa_d, ob_q, ob_d;
  logic [3:0]  rd_q, rd_d;
  logic [1:0]  idx_q, idx_d;
  logic [17:0] rnd_q;
  logic        err_q, err_d;

  logic [SBOX_LAT-1:0]      vld_q;
  logic [SBOX_LAT-1:0][1:0] tag_q;

  logic       issue, inflight, cap;
  logic [1:0] cap_tag, nib;

  assign issue    = (st_q == ISSUE) && rnd_valid;
  assign inflight = |vld_q;
  assign cap      = vld_q[SBOX_LAT-1];
  assign cap_tag  = tag_q[SBOX_LAT-1];
  // idx 0 is the most significant nibble
  assign nib      = ~idx_q;

  assign rnd_ack  = issue | inflight;
  assign sb_a_in  = issue ? a_q[{nib, 2'b00} +: 4] : 4'h0;
  assign sb_b_in  = issue ? b_q[{nib, 2'b00} +: 4] : 4'h0;
  assign sb_rnd   = (rnd_ack && rnd_valid) ? rnd_in : rnd_q;
  assign sb_round = rd_q;
  assign out_a    = oa_q;
  assign out_b    = ob_q;
  assign busy     = (st_q == ISSUE) || (st_q == DRAIN);
  assign done     = (st_q == DONE);
  assign rnd_err  = err_q;

  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    idx_d = idx_q;
    oa_d  = oa_q;
    ob_d  = ob_q;
    // the SBox cannot stall, so missing randomness under in-flight work is only flagged
    err_d = err_q | (inflight & ~rnd_valid);
    if (cap) begin
      oa_d[{~cap_tag, 2'b00} +: 4] = sb_a_out;
      ob_d[{~cap_tag, 2'b00} +: 4] = sb_b_out;
    end
    case (st_q)
      IDLE: if (start) begin
        a_d   = state_a;
        b_d   = state_b;
        rd_d  = round;
        oa_d  = 16'h0;
        ob_d  = 16'h0;
        idx_d = 2'd0;
        st_d  = ISSUE;
      end
      ISSUE: if (rnd_valid) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) st_d = DRAIN;
      end
      DRAIN: if (cap && cap_tag == 2'd3) st_d = DONE;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      idx_q <= '0;
      oa_q  <= '0;
      ob_q  <= '0;
      rnd_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      st_q     <= st_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      idx_q    <= idx_d;
      oa_q     <= oa_d;
      ob_q     <= ob_d;
      rnd_q    <= sb_rnd;
      err_q    <= err_d;
      vld_q[0] <= issue;
      tag_q[0] <= idx_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sbox_nibble_sched.sv
// Bench for sbox_nibble_sched: a behavioural masked SBox plus a scoreboard of expected unmasked results.
module tb_sbox_nibble_sched;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] state_a = '0, state_b = '0;
  logic [3:0]  round = '0;
  logic [17:0] rnd_in = '0;
  logic        rnd_valid = 1'b0;
  logic        rnd_ack;
  logic [3:0]  sb_a_in, sb_b_in, sb_round, sb_a_out, sb_b_out;
  logic [17:0] sb_rnd;
  logic [15:0] out_a, out_b;
  logic        busy, done, rnd_err;

  sbox_nibble_sched #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .state_a(state_a), .state_b(state_b),
    .round(round), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
    .sb_a_in(sb_a_in), .sb_b_in(sb_b_in), .sb_rnd(sb_rnd), .sb_round(sb_round),
    .sb_a_out(sb_a_out), .sb_b_out(sb_b_out), .out_a(out_a), .out_b(out_b),
    .busy(busy), .done(done), .rnd_err(rnd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    case (x)
      4'h0: sbox_f = 4'h9; 4'h1: sbox_f = 4'h4; 4'h2: sbox_f = 4'hA; 4'h3: sbox_f = 4'hB;
      4'h4: sbox_f = 4'hD; 4'h5: sbox_f = 4'h1; 4'h6: sbox_f = 4'h8; 4'h7: sbox_f = 4'h5;
      4'h8: sbox_f = 4'h6; 4'h9: sbox_f = 4'h2; 4'hA: sbox_f = 4'h0; 4'hB: sbox_f = 4'h3;
      4'hC: sbox_f = 4'hC; 4'hD: sbox_f = 4'hE; 4'hE: sbox_f = 4'hF; default: sbox_f = 4'h7;
    endcase
  endfunction

  function automatic logic [15:0] sbox16(input logic [15:0] x);
    sbox16 = {sbox_f(x[15:12]), sbox_f(x[11:8]), sbox_f(x[7:4]), sbox_f(x[3:0])};
  endfunction

  // masked SBox model: output share B is a fresh mask taken from the randomness bus
  logic [3:0] pa [LAT];
  logic [3:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= sbox_f(sb_a_in ^ sb_b_in) ^ sb_rnd[3:0] ^ sb_rnd[17:14];
    pb[0] <= sb_rnd[3:0] ^ sb_rnd[17:14];
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign sb_a_out = pa[LAT-1];
  assign sb_b_out = pb[LAT-1];

  typedef struct { logic [15:0] x; logic [3:0] rd; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] last_ob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one operation; start is raised in the current cycle and sampled at the next edge
  task automatic run(input logic [15:0] sa, input logic [15:0] sb, input logic [3:0] rd,
                     input int pre, input int starve, input bit poke,
                     input int exp_lat, input bit exp_err);
    exp_t e;
    int ti, nbusy, lat;
    ti = 0; nbusy = 0; lat = -1;
    state_a = sa; state_b = sb; round = rd; start = 1'b1;
    e.x = sbox16(sa ^ sb); e.rd = rd;
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    // the block must work from its latched copies
    state_a = 16'($urandom); state_b = 16'($urandom); round = 4'($urandom);
    for (int k = 0; k < 40; k++) begin
      rnd_valid = !(k < pre) && (k != starve);
      rnd_in    = 18'($urandom);
      start     = poke && (k == 2 || k == exp_lat - 1);
      @(negedge clk);
      if (busy) nbusy++;
      if (k < pre) begin
        chk("bubble_in", {sb_a_in, sb_b_in}, 8'h00);
        chk("bubble_ack", rnd_ack, 1'b0);
      end else if (rnd_valid && ti < 4) begin
        chk("issue_a", sb_a_in, 4'((sa >> (4 * (3 - ti))) & 16'hF));
        chk("issue_b", sb_b_in, 4'((sb >> (4 * (3 - ti))) & 16'hF));
        chk("issue_rnd", sb_rnd, rnd_in);
        chk("issue_ack", rnd_ack, 1'b1);
        chk("issue_round", sb_round, rd);
        ti++;
      end
      if (done) begin
        lat = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rnd_valid = 1'b1;
    if (lat < 0) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("latency", lat, exp_lat);
      chk("busy_cycles", nbusy, exp_lat - 1);
      chk("result", out_a ^ out_b, e.x);
      chk("done_round", sb_round, e.rd);
      chk("rnd_err", rnd_err, exp_err);
      last_ob = out_b;
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_pulse", {busy, done}, 2'b00);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] m, ob0;
    int nvary;
    rnd_valid = 1'b1;
    rnd_in = 18'h2AAAA;
    idle(3);
    @(negedge clk);
    chk("por_out", {out_a, out_b}, 32'h0);
    chk("por_sb", {sb_a_in, sb_b_in, sb_rnd, sb_round}, 30'h0);
    chk("por_flags", {busy, done, rnd_ack, rnd_err}, 4'h0);
    rst = 1'b1;
    idle(2);

    // abort in the middle of issue
    state_a = 16'h0123; state_b = 16'h0; round = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rnd_in = 18'h3FFFF;
    rst = 1'b0;
    #1;
    chk("arst_sb", {sb_a_in, sb_b_in, sb_rnd, sb_round}, 30'h0);
    chk("arst_out", {out_a, out_b}, 32'h0);
    chk("arst_flags", {busy, done, rnd_ack, rnd_err}, 4'h0);
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_idle", {busy, done}, 2'b00);
    end
    idle(1);

    run(16'h0123, 16'h0000, 4'h1, 0, -1, 1'b0, 4 + LAT + 1, 1'b0);
    chk("basic_x", out_a ^ out_b, 16'h94AB);
    idle(2);

    nvary = 0;
    ob0 = 16'h0;
    for (int r = 0; r < 50; r++) begin
      m = 16'($urandom);
      run(16'hA5F0 ^ m, m, 4'($urandom), 0, -1, 1'b0, 4 + LAT + 1, 1'b0);
      if (r == 0) ob0 = last_ob;
      else if (last_ob != ob0) nvary++;
      idle(1);
    end
    chk("mask_vary", nvary > 0, 1'b1);

    run(16'hBEEF, 16'h1234, 4'h7, 2, -1, 1'b0, 4 + LAT + 1 + 2, 1'b0);
    idle(2);

    // stray starts during busy and on done, then a back-to-back run
    run(16'hC3A9, 16'h5A5A, 4'h9, 0, -1, 1'b1, 4 + LAT + 1, 1'b0);
    run(16'h0F1E, 16'h7777, 4'hE, 0, -1, 1'b0, 4 + LAT + 1, 1'b0);
    idle(2);

    // starve randomness with two nibbles in flight
    run(16'h4321, 16'h9999, 4'h3, 0, 5, 1'b0, 4 + LAT + 1, 1'b1);
    idle(2);
    run(16'h0123, 16'h0000, 4'h2, 0, -1, 1'b0, 4 + LAT + 1, 1'b1);
    rst = 1'b0;
    #1;
    chk("err_clear", rnd_err, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sbox_nibble_sched.md
Name: sbox_nibble_sched

Overview:
- Sequences the four nibbles of a 16-bit two-share (A/B) SAES state through one shared masked SBox instance.
- Streams one nibble per cycle into the SBox and forwards 18 bits of fresh randomness per cycle from an external PRNG.
- Tracks in-flight nibbles with a valid/tag pipeline and reassembles both output shares.
- Implements the masked SubNibbles step; sits between the round controller and the SBox.

Parameters:
- SBOX_LAT, 3: registered latency of the attached SBox, from sb_a_in/sb_b_in to sb_a_out/sb_b_out, in cycles (≥1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin SubNibbles; sampled only in IDLE.
- state_a, input, 16: share A of the state.
- state_b, input, 16: share B of the state.
- round, input, 4: round number, latched at start.
- rnd_in, input, 18: fresh randomness.
- rnd_valid, input, 1: rnd_in is fresh this cycle.
- rnd_ack, output, 1: rnd_in consumed this cycle.
- sb_a_in, output, 4: to SBox A.
- sb_b_in, output, 4: to SBox B.
- sb_rnd, output, 18: packed {Az0,Bz0,Az1,Bz1,Az2,Bz2,Z0,Z1,Z2}, MSB first, 2 bits each.
- sb_round, output, 4: to SBox round.
- sb_a_out, input, 4: from SBox A_out.
- sb_b_out, input, 4: from SBox B_out.
- out_a, output, 16: result share A.
- out_b, output, 16: result share B.
- busy, output, 1: high in ISSUE and DRAIN.
- done, output, 1: one-cycle completion pulse.
- rnd_err, output, 1: sticky randomness-starvation flag.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. out_a, out_b, sb_a_in, sb_b_in, sb_rnd, sb_round, latched shares, issue counter and valid pipeline all clear to 0. busy, done, rnd_ack and rnd_err are 0.
- Reset mid-operation aborts: no done, and partial results are discarded.
- States:
  - IDLE: on start=1, latch state_a/state_b/round, clear out_a/out_b, issue index=0, go to ISSUE. start during any other state is ignored.
  - ISSUE: each cycle with rnd_valid=1, drive nibble [idx] of both shares on sb_a_in/sb_b_in and rnd_in on sb_rnd. Assert rnd_ack, push valid=1 with tag idx into the SBOX_LAT-deep tracking pipe, then increment idx. After idx 3 is issued, go to DRAIN.
  - ISSUE with rnd_valid=0: bubble. Drive sb_a_in=sb_b_in=0, hold sb_rnd, push valid=0, idx unchanged.
  - DRAIN: issue nothing (inputs 0). When the tag-3 result is captured, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. out_a/out_b hold until the next start.
- Nibble order: idx 0 = bits [15:12], idx 3 = bits [3:0].
- Capture: when the pipe output is valid with tag t, write sb_a_out into out_a nibble t and sb_b_out into out_b nibble t on that edge.
- Shares are never XORed together inside this block.
- Randomness:
  - rnd_ack=1 every cycle that is an issue cycle or has any in-flight valid entry (later SBox stages consume randomness too).
  - If rnd_ack would be required by in-flight entries while rnd_valid=0, the in-flight entries still advance (the SBox has no stall). rnd_err is set and stays set until reset.
- sb_round = latched round for the entire operation.
- Latency with no stalls: done is high (4+SBOX_LAT+1) cycles after the start edge, i.e. 8 for SBOX_LAT=3. Each issue bubble adds exactly one cycle.
- busy=1 from the cycle after start acceptance through the last DRAIN cycle; 0 in DONE and IDLE.

Test Plan:
1. Reset value: assert rst low mid-ISSUE -> all outputs 0 immediately. After release, state is IDLE; start with state_a=0x0123, state_b=0x0000 gives a full run.
2. Basic: state_a=0x0123, state_b=0x0000, rnd_valid=1 constant, random rnd_in -> done exactly 8 cycles after start, out_a^out_b=0x94AB, rnd_err=0, busy high for 7 cycles.
3. Masked: state_a=0xA5F0^M, state_b=M for random M, 50 runs -> out_a^out_b=0x0179 every run; out_b differs across runs.
4. Stall: rnd_valid=0 for the 2 cycles before the first issue -> done at cycle 10, correct result, rnd_err=0, sb_a_in=sb_b_in=0 during bubbles.
5. Starvation: drop rnd_valid while 2 nibbles are in flight and issue is complete -> rnd_err=1 sticky, done still fires and captures 4 nibbles; rnd_err clears only on reset.
6. Protocol: start pulses during busy and on the done cycle are ignored; start on the first IDLE cycle after done -> back-to-back second run correct, sb_round tracks the new round value.
